// File: rtl/commit_chk_pkg.sv
// Shared types for the commit checker: trace record kinds, the record layout and FSM states.
// State set grows a FAIL state when COMMIT_CHK_STOP_ON_ERR_EN is defined.
package commit_chk_pkg;

  typedef enum logic [1:0] {
    KIND_REG   = 2'b00,
    KIND_LOAD  = 2'b01,
    KIND_STORE = 2'b10,
    KIND_HALT  = 2'b11
  } kind_e;

  typedef struct packed {
    kind_e       kind;
    logic [15:0] addr;
    logic [15:0] data;
  } rec_t;

`ifdef COMMIT_CHK_STOP_ON_ERR_EN
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2,
    ST_FAIL   = 2'd3
  } state_e;
`else
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } state_e;
`endif

  localparam int MAX_EVENTS = 4;

  // HALT records carry no payload, so only the kind takes part in the comparison.
  function automatic logic recMatch(input rec_t expRec, input rec_t obsRec);
    if (obsRec.kind != expRec.kind) return 1'b0;
    if (obsRec.kind == KIND_HALT) return 1'b1;
    return (obsRec.addr == expRec.addr) && (obsRec.data == expRec.data);
  endfunction

endpackage

// File: rtl/commit_chk_fifo.sv
// Expected-record FIFO: single push, up to four pops per cycle, head+0..head+3 visible combinationally.
module commit_chk_fifo
  import commit_chk_pkg::*;
#(
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push,
  input  rec_t                          pushRec,
  input  logic [2:0]                    popCount,
  output rec_t [MAX_EVENTS-1:0]         headRec,
  output logic [$clog2(FIFO_DEPTH):0]   count
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  rec_t           mem [FIFO_DEPTH];
  logic [PW-1:0]  headPtr;
  logic [PW-1:0]  tailPtr;

  // Pointers are PW bits wide, so wrapping modulo FIFO_DEPTH is free.
  always_ff @(posedge clk) begin
    if (rst) begin
      headPtr <= '0;
      tailPtr <= '0;
      count   <= '0;
    end else begin
      if (push) begin
        mem[tailPtr] <= pushRec;
        tailPtr      <= tailPtr + 1'b1;
      end
      headPtr <= headPtr + PW'(popCount);
      count   <= count + CW'(push) - CW'(popCount);
    end
  end

  always_comb begin
    for (int i = 0; i < MAX_EVENTS; i++) begin
      headRec[i] = mem[headPtr + PW'(i)];
    end
  end

endmodule

// File: rtl/commit_checker.sv
// Compares committed REG/LOAD/STORE/HALT events against a queue of expected trace records.
// Define COMMIT_CHK_STOP_ON_ERR_EN to enter a terminal FAIL state on the first mismatch/underflow.
module commit_checker
  import commit_chk_pkg::*;
#(
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  // Record handshake: a record transfers on any rising edge where exp_valid && exp_ready.
  input  logic        exp_valid,
  output logic        exp_ready,
  input  logic [1:0]  exp_kind,
  input  logic [15:0] exp_addr,
  input  logic [15:0] exp_data,
  input  logic        reg_write,
  input  logic [2:0]  write_reg,
  input  logic [15:0] write_data,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [15:0] mem_addr,
  input  logic [15:0] mem_data_in,
  input  logic [15:0] mem_data_out,
  input  logic        halt,
  output logic        mismatch,
  output logic [15:0] err_count,
  output logic [15:0] event_count,
  output logic        underflow,
  output logic        done,
  output logic        pass,
  output state_e      dbgState
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_e                state;
  state_e                stateNext;
  logic                  active;
  logic                  push;
  rec_t                  pushRec;
  rec_t [MAX_EVENTS-1:0] headRec;
  logic [CW-1:0]         fifoCount;
  logic [2:0]            popCount;

  logic [MAX_EVENTS-1:0] evPresent;
  rec_t [MAX_EVENTS-1:0] evRec;
  logic [2:0]            evCount;
  logic [2:0]            missCnt;
  logic                  underflowNow;
  logic                  missNow;
  logic [2:0]            errAdd;
  logic [16:0]           errSum;
  logic [15:0]           errNext;

  assign active    = (state == ST_IDLE) || (state == ST_RUN);
  assign exp_ready = active && (fifoCount < CW'(FIFO_DEPTH));
  assign push      = exp_valid && exp_ready;
  assign pushRec   = '{kind: kind_e'(exp_kind), addr: exp_addr, data: exp_data};
  assign dbgState  = state;

  // Events in fixed commit order; event i is compared against head + (events present before it).
  always_comb begin
    evPresent = {halt, mem_write, mem_read, reg_write};
    evRec[0]  = '{kind: KIND_REG,   addr: {13'd0, write_reg}, data: write_data};
    evRec[1]  = '{kind: KIND_LOAD,  addr: mem_addr,           data: mem_data_out};
    evRec[2]  = '{kind: KIND_STORE, addr: mem_addr,           data: mem_data_in};
    evRec[3]  = '{kind: KIND_HALT,  addr: 16'd0,              data: 16'd0};
    evCount   = '0;
    missCnt   = '0;
    for (int i = 0; i < MAX_EVENTS; i++) begin
      if (evPresent[i]) begin
        if (!recMatch(headRec[evCount[1:0]], evRec[i])) missCnt = missCnt + 3'd1;
        evCount = evCount + 3'd1;
      end
    end
  end

  always_comb begin
    underflowNow = active && (CW'(evCount) > fifoCount);
    missNow      = active && !underflowNow && (missCnt != 3'd0);
    popCount     = (active && !underflowNow) ? evCount : 3'd0;
    errAdd       = !active ? 3'd0 : (underflowNow ? 3'd1 : missCnt);
    errSum       = {1'b0, err_count} + {14'd0, errAdd};
    errNext      = errSum[16] ? 16'hFFFF : errSum[15:0];
  end

  always_comb begin
    stateNext = state;
    case (state)
      ST_IDLE: begin
        if (halt) stateNext = ST_HALTED;
        else if ((evCount != 3'd0) || push) stateNext = ST_RUN;
      end
      ST_RUN: begin
        if (halt) stateNext = ST_HALTED;
      end
      default: stateNext = state;
    endcase
`ifdef COMMIT_CHK_STOP_ON_ERR_EN
    if (underflowNow || missNow) stateNext = ST_FAIL;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      mismatch    <= 1'b0;
      underflow   <= 1'b0;
      err_count   <= '0;
      event_count <= '0;
      pass        <= 1'b0;
    end else begin
      state     <= stateNext;
      mismatch  <= underflowNow || missNow;
      underflow <= underflowNow;
      if (active) begin
        err_count   <= errNext;
        event_count <= event_count + {13'd0, evCount};
      end
      // Verdict is fixed on the halt cycle: no errors and nothing left behind after its pops.
      if (active && halt) pass <= (errNext == 16'd0) && (fifoCount == CW'(popCount));
    end
  end

`ifdef COMMIT_CHK_STOP_ON_ERR_EN
  assign done = (state == ST_HALTED) || (state == ST_FAIL);
`else
  assign done = (state == ST_HALTED);
`endif

  commit_chk_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .pushRec  (pushRec),
    .popCount (popCount),
    .headRec  (headRec),
    .count    (fifoCount)
  );

endmodule

// File: tb/tb_commit_checker.sv
// Directed bench for commit_checker: hand-computed expectations checked with immediate assertions.
module tb_commit_checker;
  import commit_chk_pkg::*;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        exp_valid = 1'b0;
  logic        exp_ready;
  logic [1:0]  exp_kind = 2'b00;
  logic [15:0] exp_addr = '0;
  logic [15:0] exp_data = '0;
  logic        reg_write = 1'b0;
  logic [2:0]  write_reg = '0;
  logic [15:0] write_data = '0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [15:0] mem_addr = '0;
  logic [15:0] mem_data_in = '0;
  logic [15:0] mem_data_out = '0;
  logic        halt = 1'b0;
  logic        mismatch;
  logic [15:0] err_count;
  logic [15:0] event_count;
  logic        underflow;
  logic        done;
  logic        pass;
  state_e      dbgState;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  commit_checker #(.FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .exp_valid(exp_valid), .exp_ready(exp_ready), .exp_kind(exp_kind),
    .exp_addr(exp_addr), .exp_data(exp_data),
    .reg_write(reg_write), .write_reg(write_reg), .write_data(write_data),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_data_in(mem_data_in), .mem_data_out(mem_data_out), .halt(halt),
    .mismatch(mismatch), .err_count(err_count), .event_count(event_count),
    .underflow(underflow), .done(done), .pass(pass), .dbgState(dbgState)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clearCommits();
    reg_write = 1'b0; mem_read = 1'b0; mem_write = 1'b0; halt = 1'b0;
  endtask

  task automatic doReset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic pushRec(input logic [1:0] k, input logic [15:0] a, input logic [15:0] d);
    exp_valid = 1'b1; exp_kind = k; exp_addr = a; exp_data = d;
    tick();
    exp_valid = 1'b0;
  endtask

  task automatic commitReg(input logic [2:0] r, input logic [15:0] d);
    reg_write = 1'b1; write_reg = r; write_data = d;
    tick();
    clearCommits();
  endtask

  task automatic commitStore(input logic [15:0] a, input logic [15:0] d);
    mem_write = 1'b1; mem_addr = a; mem_data_in = d;
    tick();
    clearCommits();
  endtask

  task automatic commitHalt();
    halt = 1'b1;
    tick();
    clearCommits();
  endtask

  initial begin
    // Reset state
    tick();
    check("rst_mismatch", 32'(mismatch), 0);
    check("rst_err", 32'(err_count), 0);
    check("rst_events", 32'(event_count), 0);
    check("rst_underflow", 32'(underflow), 0);
    check("rst_done", 32'(done), 0);
    check("rst_pass", 32'(pass), 0);
    check("rst_ready", 32'(exp_ready), 1);
    check("rst_state", 32'(dbgState), 32'(ST_IDLE));
    rst = 1'b0;

    // Single REG match
    pushRec(2'b00, 16'd3, 16'h1234);
    commitReg(3'd3, 16'h1234);
    check("reg_mismatch", 32'(mismatch), 0);
    check("reg_err", 32'(err_count), 0);
    check("reg_events", 32'(event_count), 1);
    check("reg_state", 32'(dbgState), 32'(ST_RUN));
    tick();
    check("reg_mismatch_late", 32'(mismatch), 0);

    // REG + LOAD in one cycle
    pushRec(2'b00, 16'd1, 16'h0005);
    pushRec(2'b01, 16'h0040, 16'hBEEF);
    check("two_count_before", 32'(dut.fifoCount), 2);
    reg_write = 1'b1; write_reg = 3'd1; write_data = 16'h0005;
    mem_read = 1'b1; mem_addr = 16'h0040; mem_data_out = 16'hBEEF;
    tick();
    clearCommits();
    check("two_count_after", 32'(dut.fifoCount), 0);
    check("two_err", 32'(err_count), 0);
    check("two_events", 32'(event_count), 3);
    check("two_mismatch", 32'(mismatch), 0);

    // STORE data mismatch
    pushRec(2'b10, 16'h0010, 16'h00AA);
    commitStore(16'h0010, 16'h00AB);
    check("st_mismatch", 32'(mismatch), 1);
    check("st_err", 32'(err_count), 1);
    check("st_events", 32'(event_count), 4);
    check("st_underflow", 32'(underflow), 0);
    tick();
    check("st_mismatch_pulse", 32'(mismatch), 0);

    // Underflow on empty FIFO, then a REG address mismatch
    doReset();
    check("rst2_err", 32'(err_count), 0);
    check("rst2_events", 32'(event_count), 0);
    commitReg(3'd0, 16'h0000);
    check("uf_underflow", 32'(underflow), 1);
    check("uf_mismatch", 32'(mismatch), 1);
    check("uf_err", 32'(err_count), 1);
    check("uf_count", 32'(dut.fifoCount), 0);
    tick();
    check("uf_pulse", 32'(underflow), 0);
    pushRec(2'b00, 16'd2, 16'h0007);
    commitReg(3'd5, 16'h0007);
    check("addr_mismatch", 32'(mismatch), 1);
    check("addr_err", 32'(err_count), 2);
    check("addr_events", 32'(event_count), 2);
    check("addr_underflow", 32'(underflow), 0);

    // Fill to depth, refused push concurrent with a pop, drain through the wrap
    doReset();
    exp_valid = 1'b1; exp_kind = 2'b00; exp_addr = 16'd0;
    for (int i = 0; i < DEPTH; i++) begin
      exp_data = 16'(i);
      tick();
    end
    exp_valid = 1'b0;
    check("full_ready", 32'(exp_ready), 0);
    check("full_count", 32'(dut.fifoCount), DEPTH);
    exp_valid = 1'b1; exp_data = 16'h0099;
    reg_write = 1'b1; write_reg = 3'd0; write_data = 16'h0000;
    check("full_ready_pop", 32'(exp_ready), 0);
    tick();
    exp_valid = 1'b0;
    clearCommits();
    check("full_count_after", 32'(dut.fifoCount), DEPTH - 1);
    check("full_ready_after", 32'(exp_ready), 1);
    for (int i = 1; i < DEPTH; i++) commitReg(3'd0, 16'(i));
    check("drain_err", 32'(err_count), 0);
    check("drain_events", 32'(event_count), DEPTH);
    check("drain_count", 32'(dut.fifoCount), 0);

    // Clean halt
    doReset();
    pushRec(2'b11, 16'd0, 16'd0);
    commitHalt();
    check("halt_done", 32'(done), 1);
    check("halt_pass", 32'(pass), 1);
    check("halt_ready", 32'(exp_ready), 0);
    check("halt_events", 32'(event_count), 1);
    commitReg(3'd1, 16'h0001);
    check("halt_ignore_events", 32'(event_count), 1);
    check("halt_ignore_err", 32'(err_count), 0);

    // Halt leaving a record behind
    doReset();
    pushRec(2'b11, 16'd0, 16'd0);
    pushRec(2'b00, 16'd1, 16'h0001);
    commitHalt();
    check("left_done", 32'(done), 1);
    check("left_pass", 32'(pass), 0);
    check("left_err", 32'(err_count), 0);

    // Halt after an earlier mismatch
    doReset();
    pushRec(2'b10, 16'h0010, 16'h00AA);
    commitStore(16'h0010, 16'h00AB);
`ifdef COMMIT_CHK_STOP_ON_ERR_EN
    check("stop_done", 32'(done), 1);
    check("stop_pass", 32'(pass), 0);
    check("stop_ready", 32'(exp_ready), 0);
    pushRec(2'b11, 16'd0, 16'd0);
    commitHalt();
    check("stop_err_frozen", 32'(err_count), 1);
    check("stop_state", 32'(dbgState), 32'(ST_FAIL));
`else
    check("err_done_early", 32'(done), 0);
    pushRec(2'b11, 16'd0, 16'd0);
    commitHalt();
    check("err_done", 32'(done), 1);
    check("err_pass", 32'(pass), 0);
    check("err_err", 32'(err_count), 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/commit_checker.md
COMMIT_CHECKER -- requirements
Module: commit_checker

Interface
REQ-001 Parameter: FIFO_DEPTH, default 8, expected-record buffer depth (power of 2, at least 4).
REQ-002 Port: clk  in  1  sole clock; all state updates on its rising edge.
REQ-003 Port: rst  in  1  reset, synchronous and active-high.
REQ-004 Port: exp_valid  in  1  expected trace record offered.
REQ-005 Port: exp_ready  out  1  record accepted this cycle when exp_valid is also high.
REQ-006 Port: exp_kind  in  2  record kind: 00 REG, 01 LOAD, 10 STORE, 11 HALT.
REQ-007 Port: exp_addr  in  16  register number (REG, bits 2:0) or memory address (LOAD/STORE).
REQ-008 Port: exp_data  in  16  expected value; ignored for HALT.
REQ-009 Ports: reg_write 1, write_reg 3, write_data 16, mem_read 1, mem_write 1, mem_addr 16, mem_data_in 16, mem_data_out 16, halt 1; all inputs, sampled each cycle as committed events.
REQ-010 Ports, outputs: mismatch 1, err_count 16, event_count 16, underflow 1, done 1, pass 1.

Function
REQ-011 A cycle's committed events, in this fixed order, SHALL be: REG (reg_write), LOAD (mem_read), STORE (mem_write), HALT (halt). n is the number present, 0..4.
REQ-012 Event i SHALL be compared against the FIFO entry at head+i. A match requires equal kind and equal data. For REG, address equality uses write_reg zero-extended. For LOAD, data is mem_data_out. For STORE, data is mem_data_in. For HALT, only kind is compared.
REQ-013 If the FIFO count at the start of the cycle is at least n, the checker SHALL pop n entries that cycle.
REQ-014 Otherwise the checker SHALL pop nothing, pulse underflow the next cycle, and add 1 to err_count.
REQ-015 err_count SHALL add the number of mismatching events, saturating at 0xFFFF.
REQ-016 mismatch SHALL be a one-cycle pulse, one cycle after any mismatch or underflow.
REQ-017 event_count SHALL add n each cycle, wrapping modulo 2^16.
REQ-018 exp_ready SHALL equal (count < FIFO_DEPTH), using the count before this cycle's pops.
REQ-019 A simultaneous push and pop SHALL both take effect. The next count is count + push - pops.
REQ-020 Pointers SHALL wrap modulo FIFO_DEPTH.
REQ-021 State machine:
- IDLE to RUN on the first cycle with n > 0 or a push.
- RUN to HALTED when halt is committed.
- HALTED is terminal until rst.
REQ-022 In HALTED:
- done SHALL be 1.
- pass SHALL be 1 only if err_count == 0 and the FIFO is empty after the halt cycle's pops.
- Commit inputs and pushes SHALL be ignored, and exp_ready SHALL be 0.
REQ-023 done and pass SHALL update one cycle after the halt cycle.

Reset
REQ-024 When rst is sampled high, the checker SHALL be in IDLE with the FIFO empty, exp_ready 1, and all other outputs 0.
REQ-025 rst asserted mid-run SHALL discard the FIFO contents and counters, with no partial pop or push that cycle.

Configuration
REQ-026 With COMMIT_CHK_STOP_ON_ERR_EN defined:
- The first mismatch or underflow SHALL move the checker to a terminal FAIL state.
- In FAIL, done is 1, pass is 0, and err_count is frozen.
- Subsequent commits and pushes SHALL be ignored.
REQ-027 Without COMMIT_CHK_STOP_ON_ERR_EN, there is no FAIL state and checking continues to halt as described in REQ-021 to REQ-023.

Structure
REQ-028 Package commit_chk_pkg SHALL hold:
- the kind enum (REG, LOAD, STORE, HALT);
- the record struct {kind, addr, data};
- the state enum.
REQ-029 Sub-module commit_chk_fifo SHALL implement the FIFO:
- one push port;
- combinational head+0..head+3 read outputs;
- a pop-count input of 0..4;
- a count output.

Verification
REQ-030 Push REG r3=0x1234, then commit reg_write write_reg=3 write_data=0x1234 -> err_count 0, event_count 1, mismatch never asserted.
REQ-031 Push REG r1=0x0005 and LOAD 0x0040=0xBEEF, then in one cycle commit reg_write r1=0x0005 and mem_read addr 0x0040 data 0xBEEF -> 2 pops, count 0, err_count 0.
REQ-032 Push STORE 0x0010=0x00AA, then commit mem_write 0x0010 data 0x00AB -> mismatch pulses one cycle later, err_count 1.
REQ-033 With the FIFO empty, commit reg_write -> underflow pulses, err_count 1, no pop.
REQ-034 Push 8 records with no commits -> exp_ready 0 at count 8. Then a push concurrent with 1 commit -> push refused that cycle; next cycle count 7 and exp_ready 1.
REQ-035 Push HALT, then commit halt -> done 1 and pass 1 next cycle. Repeat with one earlier mismatch -> pass 0. With COMMIT_CHK_STOP_ON_ERR_EN, that mismatch -> done 1 immediately and the halt is ignored.
